// File: rtl/ebpc_pkg.sv
// Shared EBPC definitions: widths, symbol prefixes and lengths, decoder state
// and the decoded block layout. The encoder uses the same package.
package ebpc_pkg;

  localparam int DATA_W     = 8;
  localparam int BLOCK_SIZE = 8;
  localparam int LOGW       = $clog2(DATA_W);
  localparam int LOGP       = $clog2(BLOCK_SIZE - 1);
  localparam int PLANE_W    = BLOCK_SIZE - 1;
  localparam int BUF_W      = 2 * DATA_W;
  localparam int FILL_W     = $clog2(BUF_W + 1);
  // Wide enough for a plane index and for the longest run (2^LOGW + 1).
  localparam int PCNT_W     = $clog2(DATA_W + 2);

  // Prefix codes, first transmitted bit on the left.
  localparam logic [0:0] PFX_RAW    = 1'b1;
  localparam logic [1:0] PFX_ZERO   = 2'b01;
  localparam logic [2:0] PFX_RUN    = 3'b001;
  localparam logic [4:0] PFX_ONES   = 5'b00000;
  localparam logic [4:0] PFX_DBPZ   = 5'b00001;
  localparam logic [4:0] PFX_DOUBLE = 5'b00010;
  localparam logic [4:0] PFX_SINGLE = 5'b00011;

  // Full symbol lengths in bits, including any payload field.
  localparam logic [FILL_W-1:0] LEN_BASE   = FILL_W'(DATA_W);
  localparam logic [FILL_W-1:0] LEN_RAW    = FILL_W'(1 + PLANE_W);
  localparam logic [FILL_W-1:0] LEN_ZERO   = FILL_W'(2);
  localparam logic [FILL_W-1:0] LEN_RUN    = FILL_W'(3 + LOGW);
  localparam logic [FILL_W-1:0] LEN_ONES   = FILL_W'(5);
  localparam logic [FILL_W-1:0] LEN_DBPZ   = FILL_W'(5);
  localparam logic [FILL_W-1:0] LEN_DOUBLE = FILL_W'(5 + LOGP);
  localparam logic [FILL_W-1:0] LEN_SINGLE = FILL_W'(5 + LOGP);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLANES,
    ST_RUN,
    ST_OUT
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0]              base;
    logic [DATA_W:0][PLANE_W-1:0]   dbp;
  } dbp_block_t;

  // Positions at or beyond the plane width fall off and give zero.
  function automatic logic [PLANE_W-1:0] plane_bit(input logic [LOGP-1:0] pos);
    plane_bit = PLANE_W'(1) << pos;
  endfunction

endpackage

// File: rtl/bit_unpacker.sv
// MSB-first bit buffer: accepts DATA_W-bit words, exposes a left-aligned peek
// window and drops consume_len bits per cycle. Bits past the fill count stay zero.
module bit_unpacker
  import ebpc_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data,
  input  logic              vld,
  output logic              rdy,
  input  logic              flush,
  input  logic [FILL_W-1:0] consume_len,
  output logic [DATA_W-1:0] window,
  output logic [FILL_W-1:0] fill
);

  logic [BUF_W-1:0]  bits_q, bits_shift, bits_d;
  logic [FILL_W-1:0] fill_q, fill_base, fill_d;
  logic              ready_en_q;
  logic              accept;

  // Handshake: a word transfers on a rising edge where vld and rdy are both high;
  // rdy depends only on registered state, never on vld.
  assign rdy    = ready_en_q && (fill_q <= FILL_W'(DATA_W));
  assign accept = vld && rdy;

  always_comb begin
    if (flush) begin
      bits_shift = '0;
      fill_base  = '0;
    end else begin
      bits_shift = bits_q << consume_len;
      fill_base  = fill_q - consume_len;
    end
    bits_d = bits_shift;
    fill_d = fill_base;
    // New word lands right behind whatever survives this cycle's consumption.
    if (accept) begin
      bits_d = bits_shift | ({data, {DATA_W{1'b0}}} >> fill_base);
      fill_d = fill_base + FILL_W'(DATA_W);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bits_q     <= '0;
      fill_q     <= '0;
      ready_en_q <= 1'b0;
    end else begin
      bits_q     <= bits_d;
      fill_q     <= fill_d;
      ready_en_q <= 1'b1;
    end
  end

  assign window = bits_q[BUF_W-1 -: DATA_W];
  assign fill   = fill_q;

endmodule

// File: rtl/seq_decoder.sv
// EBPC bit-plane decoder: reads a base word then one DBX symbol per plane from
// DATA_W down to 0, XOR-reconstructs the DBP planes and hands out one block.
module seq_decoder
  import ebpc_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              vld_i,
  output logic              rdy_o,
  input  logic              flush_i,
  output dbp_block_t        dbp_block_o,
  output logic              vld_o,
  input  logic              rdy_i,
  output logic              err_o,
  output logic              idle_o
);

  state_e              state_q, state_d;
  logic [PCNT_W-1:0]   plane_q, plane_d;
  logic [PCNT_W-1:0]   run_q, run_d;
  logic [PLANE_W-1:0]  prev_q, prev_d;
  dbp_block_t          block_q, block_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   window;
  logic [FILL_W-1:0]   fill;
  logic [FILL_W-1:0]   consume_len;
  logic                unpack_flush;

  logic [FILL_W-1:0]   sym_len;
  logic [PLANE_W-1:0]  sym_dbx;
  logic                sym_dbp_zero;
  logic                sym_run;
  logic [PCNT_W-1:0]   run_total;
  logic [LOGW-1:0]     run_field;
  logic [LOGP-1:0]     pos_field;
  logic [PLANE_W-1:0]  pos_bit;
  logic [PLANE_W-1:0]  plane_val;

  bit_unpacker u_unpacker (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .data        (data_i),
    .vld         (vld_i),
    .rdy         (rdy_o),
    .flush       (unpack_flush),
    .consume_len (consume_len),
    .window      (window),
    .fill        (fill)
  );

  assign run_field = window[DATA_W-4 -: LOGW];
  assign pos_field = window[DATA_W-6 -: LOGP];
  assign pos_bit   = plane_bit(pos_field);

  // Decode assumes the unfilled tail of the window is zero; any symbol whose
  // length fits in fill was therefore decoded from real bits only.
  always_comb begin
    sym_len      = LEN_RAW;
    sym_dbx      = '0;
    sym_dbp_zero = 1'b0;
    sym_run      = 1'b0;
    run_total    = '0;
    if (window[DATA_W-1] == PFX_RAW) begin
      sym_dbx = window[DATA_W-2 -: PLANE_W];
    end else if (window[DATA_W-1 -: 2] == PFX_ZERO) begin
      sym_len = LEN_ZERO;
    end else if (window[DATA_W-1 -: 3] == PFX_RUN) begin
      sym_len   = LEN_RUN;
      sym_run   = 1'b1;
      run_total = PCNT_W'(run_field) + PCNT_W'(2);
    end else begin
      case (window[DATA_W-1 -: 5])
        PFX_ONES: begin
          sym_len = LEN_ONES;
          sym_dbx = '1;
        end
        PFX_DBPZ: begin
          sym_len      = LEN_DBPZ;
          sym_dbp_zero = 1'b1;
        end
        PFX_DOUBLE: begin
          sym_len = LEN_DOUBLE;
          sym_dbx = pos_bit | (pos_bit << 1);
        end
        default: begin
          sym_len = LEN_SINGLE;
          sym_dbx = pos_bit;
        end
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    plane_d      = plane_q;
    run_d        = run_q;
    prev_d       = prev_q;
    block_d      = block_q;
    err_d        = 1'b0;
    consume_len  = '0;
    unpack_flush = 1'b0;
    plane_val    = '0;

    case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          unpack_flush = 1'b1;
        end else if (fill >= LEN_BASE) begin
          consume_len  = LEN_BASE;
          block_d.base = window;
          plane_d      = PCNT_W'(DATA_W);
          prev_d       = '0;
          state_d      = ST_PLANES;
        end
      end

      ST_PLANES: begin
        if (fill >= sym_len) begin
          consume_len            = sym_len;
          plane_val              = sym_dbp_zero ? '0 : (sym_dbx ^ prev_q);
          block_d.dbp[plane_q]   = plane_val;
          prev_d                 = plane_val;
          // A run reaching past plane 0 is cut there and flagged.
          if (sym_run && (run_total > plane_q + PCNT_W'(1))) begin
            err_d = 1'b1;
          end
          if (plane_q == '0) begin
            plane_d = PCNT_W'(DATA_W);
            state_d = ST_OUT;
          end else begin
            plane_d = plane_q - PCNT_W'(1);
            if (sym_run) begin
              run_d   = run_total - PCNT_W'(1);
              state_d = ST_RUN;
            end
          end
        end
      end

      ST_RUN: begin
        // Zero DBX: the plane simply repeats the one above it.
        plane_val            = prev_q;
        block_d.dbp[plane_q] = plane_val;
        run_d                = run_q - PCNT_W'(1);
        if (plane_q == '0) begin
          plane_d = PCNT_W'(DATA_W);
          run_d   = '0;
          state_d = ST_OUT;
        end else begin
          plane_d = plane_q - PCNT_W'(1);
          if (run_q == PCNT_W'(1)) begin
            state_d = ST_PLANES;
          end
        end
      end

      ST_OUT: begin
        if (rdy_i) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      plane_q <= PCNT_W'(DATA_W);
      run_q   <= '0;
      prev_q  <= '0;
      block_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      plane_q <= plane_d;
      run_q   <= run_d;
      prev_q  <= prev_d;
      block_q <= block_d;
      err_q   <= err_d;
    end
  end

  assign dbp_block_o = block_q;
  assign vld_o       = (state_q == ST_OUT);
  assign err_o       = err_q;
  assign idle_o      = (state_q == ST_IDLE) && (fill == '0);

endmodule

// File: tb/tb_seq_decoder.sv
// Bench for seq_decoder: random EBPC blocks are encoded from the symbol rules,
// streamed in word by word, and the decoded blocks checked against the model.
module tb_seq_decoder;
  import ebpc_pkg::*;

  localparam int BLK_W = $bits(dbp_block_t);

  logic              clk_i   = 1'b0;
  logic              rst_ni  = 1'b0;
  logic [DATA_W-1:0] data_i  = '0;
  logic              vld_i   = 1'b0;
  logic              rdy_o;
  logic              flush_i = 1'b0;
  dbp_block_t        dbp_block_o;
  logic              vld_o;
  logic              rdy_i   = 1'b1;
  logic              err_o;
  logic              idle_o;

  int n_tests = 0;
  int n_fail  = 0;
  int err_seen = 0;
  int rdy_mode = 0;
  bit bubbles  = 1'b0;

  logic [BLK_W-1:0]  exp_q[$];
  logic [BLK_W-1:0]  got_q[$];
  logic [DATA_W-1:0] tx_q[$];
  bit                bit_q[$];

  seq_decoder dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .data_i      (data_i),
    .vld_i       (vld_i),
    .rdy_o       (rdy_o),
    .flush_i     (flush_i),
    .dbp_block_o (dbp_block_o),
    .vld_o       (vld_o),
    .rdy_i       (rdy_i),
    .err_o       (err_o),
    .idle_o      (idle_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    #1;
    case (rdy_mode)
      0:       rdy_i = 1'b1;
      1:       rdy_i = ($urandom_range(0, 2) != 0);
      default: rdy_i = 1'b0;
    endcase
  end

  always @(negedge clk_i) begin
    if (rst_ni && vld_o && rdy_i) got_q.push_back(dbp_block_o);
    if (rst_ni && err_o) err_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bit_q.push_back(v[i]);
  endtask

  task automatic pack_words();
    logic [DATA_W-1:0] w;
    while (bit_q.size() % DATA_W != 0) bit_q.push_back(1'b0);
    while (bit_q.size() > 0) begin
      for (int i = DATA_W - 1; i >= 0; i--) w[i] = bit_q.pop_front();
      tx_q.push_back(w);
    end
  endtask

  // Random block from the symbol table; err_plane >= 0 places an over-long run there.
  task automatic gen_block(input int err_plane);
    logic [DATA_W-1:0]  base;
    logic [PLANE_W-1:0] dbx [DATA_W+1];
    bit                 zp  [DATA_W+1];
    logic [PLANE_W-1:0] prev, val;
    logic [BLK_W-1:0]   e;
    int k, kind, n, p;
    base = DATA_W'($urandom_range(0, 255));
    push_bits(32'(base), DATA_W);
    for (int i = 0; i <= DATA_W; i++) begin dbx[i] = '0; zp[i] = 1'b0; end
    k = DATA_W;
    while (k >= 0) begin
      if (k == err_plane) begin
        push_bits(32'b001, 3); push_bits(32'd7, 3);
        k = -1;
      end else begin
        kind = $urandom_range(0, 6);
        if (kind == 1 && (k < 1 || err_plane >= 0)) kind = 6;
        case (kind)
          0: begin push_bits(32'b01, 2); k--; end
          1: begin
            n = $urandom_range(2, (k + 1 < 9) ? k + 1 : 9);
            push_bits(32'b001, 3); push_bits(32'(n - 2), 3);
            k -= n;
          end
          2: begin push_bits(32'b00000, 5); dbx[k] = '1; k--; end
          3: begin push_bits(32'b00001, 5); zp[k] = 1'b1; k--; end
          4: begin
            p = $urandom_range(0, 7);
            push_bits(32'b00010, 5); push_bits(32'(p), 3);
            if (p < PLANE_W) dbx[k][p] = 1'b1;
            if (p + 1 < PLANE_W) dbx[k][p+1] = 1'b1;
            k--;
          end
          5: begin
            p = $urandom_range(0, 7);
            push_bits(32'b00011, 5); push_bits(32'(p), 3);
            if (p < PLANE_W) dbx[k][p] = 1'b1;
            k--;
          end
          default: begin
            val = PLANE_W'($urandom_range(0, 127));
            push_bits(32'b1, 1); push_bits(32'(val), PLANE_W);
            dbx[k] = val;
            k--;
          end
        endcase
      end
    end
    e = '0;
    e[BLK_W-1 -: DATA_W] = base;
    prev = '0;
    for (int j = DATA_W; j >= 0; j--) begin
      val = zp[j] ? '0 : (dbx[j] ^ prev);
      e[j*PLANE_W +: PLANE_W] = val;
      prev = val;
    end
    exp_q.push_back(e);
  endtask

  task automatic send_stream(input int max_cycles, output bit ok);
    int cyc = 0;
    bit fire;
    @(posedge clk_i); #1;
    vld_i  = (tx_q.size() > 0);
    data_i = (tx_q.size() > 0) ? tx_q[0] : '0;
    while (tx_q.size() > 0 && cyc < max_cycles) begin
      @(negedge clk_i);
      fire = vld_i && rdy_o;
      @(posedge clk_i); #1;
      if (fire) void'(tx_q.pop_front());
      vld_i  = (tx_q.size() > 0) && (!bubbles || $urandom_range(0, 3) != 0);
      data_i = (tx_q.size() > 0) ? tx_q[0] : '0;
      cyc++;
    end
    vld_i = 1'b0;
    ok = (tx_q.size() == 0);
    tx_q.delete();
  endtask

  task automatic wait_blocks(input int n, input int max_cycles, output bit ok);
    int cyc = 0;
    while (got_q.size() < n && cyc < max_cycles) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic do_flush();
    @(posedge clk_i); #1 flush_i = 1'b1;
    @(posedge clk_i); #1 flush_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_tests++; if (vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", vld_o); end
    n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_o); end
    n_tests++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle_o); end
    n_tests++; if (dbp_block_o !== '0) begin n_fail++; $display("FAIL reset_block: got %h want 0", dbp_block_o); end
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    n_tests++; if (rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b want 1", rdy_o); end
  endtask

  task automatic test_zero_run_flush();
    bit ok1, ok2;
    logic [BLK_W-1:0] g;
    tx_q = '{8'h00, 8'h3C};
    err_seen = 0;
    fork
      send_stream(200, ok1);
      wait_blocks(1, 300, ok2);
    join
    n_tests++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL zero_run_timeout: sent %b got %b want 1 1", ok1, ok2); end
    n_tests++;
    g = (got_q.size() > 0) ? got_q.pop_front() : {BLK_W{1'bx}};
    if (g !== '0) begin n_fail++; $display("FAIL zero_run_block: got %h want 0", g); end
    @(negedge clk_i);
    n_tests++; if (idle_o !== 1'b0) begin n_fail++; $display("FAIL zero_run_pad_held: idle got %b want 0", idle_o); end
    do_flush();
    @(negedge clk_i);
    n_tests++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL zero_run_flush_idle: got %b want 1", idle_o); end
    n_tests++; if (err_seen != 0) begin n_fail++; $display("FAIL zero_run_err: got %0d want 0", err_seen); end
  endtask

  task automatic test_all_ones();
    bit ok1, ok2;
    logic [BLK_W-1:0] e, g;
    push_bits(32'h05, 8);
    for (int i = 0; i < 9; i++) push_bits(32'b00000, 5);
    pack_words();
    e = '0;
    e[BLK_W-1 -: DATA_W] = 8'h05;
    for (int j = 0; j <= DATA_W; j++) e[j*PLANE_W +: PLANE_W] = (j % 2 == 0) ? 7'h7F : 7'h00;
    fork
      send_stream(300, ok1);
      wait_blocks(1, 400, ok2);
    join
    n_tests++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL all_ones_timeout: sent %b got %b want 1 1", ok1, ok2); end
    n_tests++;
    g = (got_q.size() > 0) ? got_q.pop_front() : {BLK_W{1'bx}};
    if (g !== e) begin n_fail++; $display("FAIL all_ones_block: got %h want %h", g, e); end
    do_flush();
  endtask

  task automatic test_raw_then_run();
    bit ok1, ok2;
    logic [BLK_W-1:0] e, g;
    push_bits(32'hA0, 8);
    push_bits(32'b1, 1); push_bits(32'h55, 7);
    push_bits(32'b001, 3); push_bits(32'b110, 3);
    pack_words();
    e = '0;
    e[BLK_W-1 -: DATA_W] = 8'hA0;
    for (int j = 0; j <= DATA_W; j++) e[j*PLANE_W +: PLANE_W] = 7'h55;
    fork
      send_stream(300, ok1);
      wait_blocks(1, 400, ok2);
    join
    n_tests++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL raw_run_timeout: sent %b got %b want 1 1", ok1, ok2); end
    n_tests++;
    g = (got_q.size() > 0) ? got_q.pop_front() : {BLK_W{1'bx}};
    if (g !== e) begin n_fail++; $display("FAIL raw_run_block: got %h want %h", g, e); end
    do_flush();
  endtask

  task automatic test_backpressure();
    bit ok1, ok2;
    int cyc;
    logic [BLK_W-1:0] g, e;
    gen_block(-1);
    gen_block(-1);
    pack_words();
    rdy_mode = 2;
    fork
      send_stream(2000, ok1);
      begin
        cyc = 0;
        @(negedge clk_i);
        while (!vld_o && cyc < 500) begin @(negedge clk_i); cyc++; end
        n_tests++; if (vld_o !== 1'b1) begin n_fail++; $display("FAIL bp_first_vld: got %b want 1", vld_o); end
        for (int i = 0; i < 10; i++) begin
          n_tests++;
          if (!vld_o || dbp_block_o !== exp_q[0]) begin
            n_fail++; $display("FAIL bp_hold_cycle%0d: vld %b block %h want %h", i, vld_o, dbp_block_o, exp_q[0]);
          end
          @(negedge clk_i);
        end
        n_tests++; if (rdy_o !== 1'b0) begin n_fail++; $display("FAIL bp_rdy_full: got %b want 0", rdy_o); end
        rdy_mode = 0;
        wait_blocks(2, 1000, ok2);
      end
    join
    n_tests++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL bp_timeout: sent %b got %b want 1 1", ok1, ok2); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : {BLK_W{1'bx}};
      n_tests++; if (g !== e) begin n_fail++; $display("FAIL bp_block: got %h want %h", g, e); end
    end
    do_flush();
  endtask

  task automatic test_run_overflow();
    bit ok1, ok2;
    logic [BLK_W-1:0] e, g;
    err_seen = 0;
    gen_block(2);
    pack_words();
    fork
      send_stream(500, ok1);
      wait_blocks(1, 600, ok2);
    join
    n_tests++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL overflow_timeout: sent %b got %b want 1 1", ok1, ok2); end
    e = exp_q.pop_front();
    g = (got_q.size() > 0) ? got_q.pop_front() : {BLK_W{1'bx}};
    n_tests++; if (g !== e) begin n_fail++; $display("FAIL overflow_block: got %h want %h", g, e); end
    n_tests++; if (err_seen != 1) begin n_fail++; $display("FAIL overflow_err_pulses: got %0d want 1", err_seen); end
    do_flush();
  endtask

  task automatic test_reset_mid_run();
    bit ok1, ok2;
    logic [BLK_W-1:0] e, g;
    push_bits(32'($urandom_range(0, 255)), 8);
    push_bits(32'b001, 3); push_bits(32'b111, 3);
    pack_words();
    send_stream(100, ok1);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b0;
    @(negedge clk_i);
    n_tests++; if (vld_o !== 1'b0) begin n_fail++; $display("FAIL midrun_vld: got %b want 0", vld_o); end
    n_tests++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL midrun_idle: got %b want 1", idle_o); end
    @(posedge clk_i); #1 rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL midrun_partial: got %0d blocks want 0", got_q.size()); end
    got_q.delete();
    err_seen = 0;
    gen_block(-1);
    gen_block(-1);
    pack_words();
    fork
      send_stream(1000, ok2);
      wait_blocks(2, 1200, ok1);
    join
    n_tests++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL midrun_timeout: got %b sent %b want 1 1", ok1, ok2); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : {BLK_W{1'bx}};
      n_tests++; if (g !== e) begin n_fail++; $display("FAIL midrun_after_block: got %h want %h", g, e); end
    end
    n_tests++; if (err_seen != 0) begin n_fail++; $display("FAIL midrun_err: got %0d want 0", err_seen); end
    do_flush();
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    int nb;
    logic [BLK_W-1:0] e, g;
    err_seen = 0;
    rdy_mode = 1;
    bubbles  = 1'b1;
    nb = 8;
    for (int i = 0; i < nb; i++) gen_block(-1);
    pack_words();
    fork
      send_stream(5000, ok1);
      wait_blocks(nb, 6000, ok2);
    join
    rdy_mode = 0;
    bubbles  = 1'b0;
    n_tests++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL b2b_timeout: sent %b got %b want 1 1", ok1, ok2); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : {BLK_W{1'bx}};
      n_tests++; if (g !== e) begin n_fail++; $display("FAIL b2b_block: got %h want %h", g, e); end
    end
    n_tests++; if (err_seen != 0) begin n_fail++; $display("FAIL b2b_err: got %0d want 0", err_seen); end
    do_flush();
    @(negedge clk_i);
    n_tests++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got %b want 1", idle_o); end
    n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL b2b_extra: got %0d extra blocks want 0", got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_zero_run_flush();
    test_all_ones();
    test_raw_then_run();
    test_backpressure();
    test_run_overflow();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_decoder.md
SEQ_DECODER -- requirements
Module: seq_decoder

Interface
REQ-001 SHALL have no parameters; DATA_W and BLOCK_SIZE come from ebpc_pkg; LOGW = $clog2(DATA_W), LOGP = $clog2(BLOCK_SIZE-1).
REQ-002 SHALL have ports: clk_i  in  1  clock; rst_ni  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: data_i  in  DATA_W  packed bitstream word, MSB first; vld_i  in  1; rdy_o  out  1.
REQ-004 SHALL have ports: flush_i  in  1  discard residual pad bits when idle.
REQ-005 SHALL have ports: dbp_block_o  out  dbp_block_t  {base, dbp[DATA_W:0]}, each plane BLOCK_SIZE-1 bits; vld_o  out  1; rdy_i  in  1.
REQ-006 SHALL have ports: err_o  out  1  one-cycle pulse on a malformed zero run; idle_o  out  1.

Function
REQ-007 Bitstream bits SHALL be consumed MSB-first from a 2*DATA_W-bit buffer with a fill count; a word is accepted (rdy_o=1) only while fill <= DATA_W.
REQ-008 Per block, SHALL read a DATA_W-bit base, then decode planes k = DATA_W down to 0, one DBX per cycle.
REQ-009 Symbol table (prefix -> DBX[k]): '01' -> one zero; '001'+L[LOGW] -> L+2 zeros; '00000' -> all ones; '00001' -> DBP[k]=0; '00010'+p[LOGP] -> ones at bits p and p+1; '00011'+p[LOGP] -> one at bit p; '1'+raw[BLOCK_SIZE-1] -> raw.
REQ-010 Reconstruction SHALL be DBP[DATA_W]=DBX[DATA_W]; DBP[k]=DBX[k] xor DBP[k+1]; for '00001', DBP[k]=0.
REQ-011 A symbol SHALL be consumed only when fill >= its full length; otherwise the FSM stalls without state change.
REQ-012 FSM states: IDLE (wait fill>=DATA_W, take base -> PLANES); PLANES (decode one symbol; run code with L+2>1 -> RUN); RUN (emit one zero DBX per cycle, no bit consumption, until run count 0); OUT (vld_o=1, hold until rdy_i -> IDLE).
REQ-013 After plane 0 is written, the FSM SHALL go to OUT; the plane counter reloads to DATA_W.
REQ-014 A run longer than the remaining planes SHALL be truncated at plane 0, pulse err_o for one cycle, and still complete the block.
REQ-015 dbp_block_o SHALL be registered and stable while vld_o=1 and rdy_i=0; new decoding SHALL not start until the block is accepted.
REQ-016 flush_i in IDLE SHALL zero the fill count the same cycle; in any other state it SHALL be ignored.
REQ-017 idle_o=1 iff state IDLE and fill==0.
REQ-018 Simultaneous word accept and symbol consumption SHALL update fill as fill+DATA_W-len in one cycle.

Reset
REQ-019 Reset SHALL force: state IDLE, fill 0, plane counter DATA_W, run count 0, vld_o 0, err_o 0, dbp_block_o all zero; rdy_o=1 one cycle after deassertion.
REQ-020 Reset mid-block SHALL drop the partial block and all buffered bits.

Structure
REQ-021 Symbol prefix codes, symbol lengths, state enum and dbp_block_t SHALL live in ebpc_pkg, shared with the encoder.
REQ-022 The bit buffer SHALL be a sub-module bit_unpacker (input word handshake, peek window, consume-length port, fill count, flush).

Verification (DATA_W=8, BLOCK_SIZE=8)
REQ-023 Words 0x00, 0x3C, then flush -> one block base=0, all 9 planes 0; idle_o=1 afterward.
REQ-024 Base 0x05, 9x '00000', padded -> DBP alternates 7F,00,7F,... from plane 8 down; plane 0 = 7F.
REQ-025 Base 0xA0, '1'+7'h55, then '001'+3'b110 -> plane 8 = 55, planes 7..0 = 55 (zero DBX run of 8).
REQ-026 rdy_i held 0 for 10 cycles at OUT -> dbp_block_o stable, rdy_o drops once buffer is full, no bits lost.
REQ-027 Plane 2 coded '001'+3'b111 -> err_o pulses once, block completes with planes 2..0 zero-DBX.
REQ-028 rst_ni asserted mid-RUN -> vld_o=0, fill=0; next clean stream decodes correctly.
